// File: rtl/perceptron_introduction_pkg.sv
// Q32.32 signed fixed-point types, constants and arithmetic helpers.
// Optional build macro PERCEPTRON_SATURATE_EN: multiply and add saturate instead of wrapping.
package FixedPoint;

   typedef logic signed [63:0] sfp;

   localparam int unsigned FRAC_BITS = 32;
   localparam sfp SFP_ONE = 64'sh0000_0001_0000_0000;
   localparam sfp SFP_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
   localparam sfp SFP_MIN = 64'sh8000_0000_0000_0000;

   function automatic sfp int_to_sfp(input int i);
      sfp r;
      r = {{32{i[31]}}, i};
      return r <<< FRAC_BITS;
   endfunction

   // Full 128-bit product, arithmetic shift drops the extra fraction bits (floor).
   function automatic sfp sfp_mul(input sfp a, input sfp b);
      logic signed [127:0] ae;
      logic signed [127:0] be;
      logic signed [127:0] p;
      logic signed [127:0] s;
      ae = {{64{a[63]}}, a};
      be = {{64{b[63]}}, b};
      p  = ae * be;
      s  = p >>> FRAC_BITS;
`ifdef PERCEPTRON_SATURATE_EN
      if (s[127:63] != '0 && s[127:63] != '1) begin
         return s[127] ? SFP_MIN : SFP_MAX;
      end
`endif
      return s[63:0];
   endfunction

   // Saturating add; one guard bit is enough to see the overflow.
   function automatic sfp sfp_add_sat(input sfp a, input sfp b);
      logic [64:0] s;
      s = {a[63], a} + {b[63], b};
      if (s[64] != s[63]) begin
         return s[64] ? SFP_MIN : SFP_MAX;
      end
      return s[63:0];
   endfunction

   // Add used by the weight update: saturating or wrapping depending on the build.
   function automatic sfp sfp_add(input sfp a, input sfp b);
`ifdef PERCEPTRON_SATURATE_EN
      return sfp_add_sat(a, b);
`else
      return a + b;
`endif
   endfunction

endpackage

// File: rtl/perceptron_dot_product.sv
// Combinational net input: net = bias + sum(w_i * x_i) in a widened accumulator.
// Optional build macro PERCEPTRON_SATURATE_EN: clamp the sum to the sfp range instead of wrapping.
module perceptron_dot_product
   import FixedPoint::*;
#(
   parameter int unsigned input_units = 2
) (
   input  sfp [input_units-1:0] weights_i,
   input  sfp                   bias_i,
   input  sfp [input_units-1:0] values_i,
   output sfp                   net_o
);

   localparam int unsigned ExtW = $clog2(input_units + 1);
   localparam int unsigned AccW = 64 + ExtW;

   logic [AccW-1:0] acc;
   sfp              prod;

   // Sum all products plus bias, then fit the wide sum back into 64 bits.
   always_comb begin
      prod = '0;
      acc  = {{ExtW{bias_i[63]}}, bias_i};
      for (int unsigned i = 0; i < input_units; i++) begin
         prod = sfp_mul(weights_i[i], values_i[i]);
         acc  = acc + {{ExtW{prod[63]}}, prod};
      end
`ifdef PERCEPTRON_SATURATE_EN
      if (acc[AccW-1:63] == '0 || acc[AccW-1:63] == '1) begin
         net_o = acc[63:0];
      end else begin
         net_o = acc[AccW-1] ? SFP_MIN : SFP_MAX;
      end
`else
      net_o = acc[63:0];
`endif
   end

`ifndef PERCEPTRON_SATURATE_EN
   // Guard bits only matter when saturating.
   logic unused_acc_hi;
   assign unused_acc_hi = ^acc[AccW-1:64];
`endif

endmodule

// File: rtl/perceptron_introduction.sv
// Single-output perceptron: step activation, on-line perceptron-rule training.
// Optional build macro PERCEPTRON_SATURATE_EN: products, net sum and updates saturate.
module perceptron_introduction
   import FixedPoint::*;
#(
   parameter int unsigned input_units = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  sfp [input_units-1:0] values,
   input  logic                 training,
   input  sfp                   learning_rate,
   input  sfp                   expected,
   output sfp                   prediction
);

   sfp [input_units-1:0] weight_q, weight_d;
   sfp                   bias_q, bias_d;
   sfp                   prediction_q;
   sfp                   net;
   sfp                   y;
   sfp                   err;
   sfp                   delta;

   perceptron_dot_product #(
      .input_units(input_units)
   ) u_dot (
      .weights_i(weight_q),
      .bias_i   (bias_q),
      .values_i (values),
      .net_o    (net)
   );

   // Activation, error and next weights; the update uses the pre-edge prediction.
   always_comb begin
      y        = (net > 64'sd0) ? SFP_ONE : '0;
      err      = expected - y;
      delta    = sfp_mul(learning_rate, err);
      weight_d = weight_q;
      bias_d   = bias_q;
      if (training) begin
         for (int unsigned i = 0; i < input_units; i++) begin
            weight_d[i] = sfp_add(weight_q[i], sfp_mul(delta, values[i]));
         end
         bias_d = sfp_add(bias_q, delta);
      end
   end

   // Weight, bias and prediction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         weight_q     <= '0;
         bias_q       <= '0;
         prediction_q <= '0;
      end else begin
         weight_q     <= weight_d;
         bias_q       <= bias_d;
         prediction_q <= y;
      end
   end

   assign prediction = prediction_q;

endmodule

// File: tb/tb_perceptron_introduction.sv
// Self-checking bench for perceptron_introduction (2 inputs) against a plain-arithmetic model.
// Honours PERCEPTRON_SATURATE_EN in the model when the macro is defined.
module tb_perceptron_introduction;
   import FixedPoint::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   sfp   [1:0]  values = '0;
   logic        training = 1'b0;
   sfp          learning_rate = '0;
   sfp          expected = '0;
   sfp          prediction;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   sfp mw0 = '0, mw1 = '0, mb = '0, mpred = '0;

   perceptron_introduction #(
      .input_units(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .values       (values),
      .training     (training),
      .learning_rate(learning_rate),
      .expected     (expected),
      .prediction   (prediction)
   );

   always #5 clk = ~clk;

   function automatic logic signed [127:0] ext(input sfp a);
      return {{64{a[63]}}, a};
   endfunction

   function automatic sfp m_fit(input logic signed [127:0] v);
`ifdef PERCEPTRON_SATURATE_EN
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = ext(SFP_MAX);
      lo = ext(SFP_MIN);
      if (v > hi) return SFP_MAX;
      if (v < lo) return SFP_MIN;
`endif
      return v[63:0];
   endfunction

   function automatic sfp m_mul(input sfp a, input sfp b);
      logic signed [127:0] f;
      f = ext(a) * ext(b);
      return m_fit(f >>> 32);
   endfunction

   function automatic sfp m_add(input sfp a, input sfp b);
      return m_fit(ext(a) + ext(b));
   endfunction

   task automatic check(input string tag, input sfp obs, input sfp exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".pred"}, prediction, mpred);
      check({tag, ".w0"}, dut.weight_q[0], mw0);
      check({tag, ".w1"}, dut.weight_q[1], mw1);
      check({tag, ".bias"}, dut.bias_q, mb);
   endtask

   // Apply inputs for one edge and advance the model by the learning rule.
   task automatic step(input sfp x0, input sfp x1, input logic tr, input sfp eta, input sfp ex);
      logic signed [127:0] acc;
      sfp net, y, e, d;
      values        = {x1, x0};
      training      = tr;
      learning_rate = eta;
      expected      = ex;
      acc = ext(mb) + ext(m_mul(mw0, x0)) + ext(m_mul(mw1, x1));
      net = m_fit(acc);
      y   = (net > 0) ? SFP_ONE : 64'sd0;
      e   = ex - y;
      d   = m_mul(eta, e);
      @(posedge clk);
      #1;
      mpred = y;
      if (tr) begin
         mw0 = m_add(mw0, m_mul(d, x0));
         mw1 = m_add(mw1, m_mul(d, x1));
         mb  = m_add(mb, d);
      end
   endtask

   // Asynchronous reset between edges, released just after an edge.
   task automatic areset(input string tag);
      rst = 1'b0;
      #2;
      mw0 = '0; mw1 = '0; mb = '0; mpred = '0;
      check_state({tag, ".async"});
      @(posedge clk);
      #1;
      check_state({tag, ".held"});
      rst = 1'b1;
   endtask

   sfp pat_x0 [4];
   sfp pat_x1 [4];
   sfp pat_y  [4];

   initial begin
      pat_x0 = '{64'sd0, 64'sd0, SFP_ONE, SFP_ONE};
      pat_x1 = '{64'sd0, SFP_ONE, 64'sd0, SFP_ONE};
      pat_y  = '{64'sd0, 64'sd0, 64'sd0, SFP_ONE};

      // Reset held for 3 cycles with arbitrary inputs.
      for (int i = 0; i < 3; i++) begin
         values        = {{$urandom, $urandom}, {$urandom, $urandom}};
         training      = 1'b1;
         learning_rate = SFP_ONE;
         expected      = SFP_ONE;
         @(posedge clk);
         #1;
         check_state("reset");
      end
      rst = 1'b1;
      step(0, 0, 1'b0, SFP_ONE, SFP_ONE);
      check_state("release");

      // Single update, then the new weights show on a zero input.
      step(SFP_ONE, SFP_ONE, 1'b1, SFP_ONE, SFP_ONE);
      check_state("single");
      check("single.w0_one", dut.weight_q[0], SFP_ONE);
      check("single.bias_one", dut.bias_q, SFP_ONE);
      step(0, 0, 1'b0, SFP_ONE, 0);
      check_state("single.after");
      check("single.pred_one", prediction, SFP_ONE);

      // Hold: expected opposite to the prediction, training off.
      for (int i = 0; i < 10; i++) begin
         sfp x0, x1;
         x0 = (($urandom & 1) != 0) ? SFP_ONE : 64'sd0;
         x1 = (($urandom & 1) != 0) ? SFP_ONE : 64'sd0;
         step(x0, x1, 1'b0, SFP_ONE, (mpred == SFP_ONE) ? 64'sd0 : SFP_ONE);
         check_state("hold");
         check("hold.w0_one", dut.weight_q[0], SFP_ONE);
      end

      // AND learning from scratch.
      areset("rst_and");
      for (int ep = 0; ep < 10; ep++) begin
         for (int p = 0; p < 4; p++) begin
            repeat (2) begin
               step(pat_x0[p], pat_x1[p], 1'b1, SFP_ONE, pat_y[p]);
               check_state("and.train");
            end
         end
      end
      for (int p = 0; p < 4; p++) begin
         step(pat_x0[p], pat_x1[p], 1'b0, SFP_ONE, 0);
         check_state("and.test");
         check("and.label", prediction, pat_y[p]);
      end

      // Latency: [1,0] sits exactly at net 0, then [1,1] shows one edge later.
      step(SFP_ONE, 0, 1'b0, SFP_ONE, 0);
      check("net_zero", prediction, 64'sd0);
      values = {SFP_ONE, SFP_ONE};
      #2;
      check("latency.pre_edge", prediction, 64'sd0);
      step(SFP_ONE, SFP_ONE, 1'b0, SFP_ONE, 0);
      check("latency.post_edge", prediction, SFP_ONE);

      // Randomized training with arbitrary operands.
      for (int i = 0; i < 40; i++) begin
         sfp x0, x1, eta;
         x0  = sfp'({$urandom, $urandom}) >>> ($urandom_range(0, 40));
         x1  = sfp'({$urandom, $urandom}) >>> ($urandom_range(0, 40));
         eta = sfp'({32'd0, $urandom});
         step(x0, x1, 1'($urandom & 1), eta, (($urandom & 1) != 0) ? SFP_ONE : 64'sd0);
         check_state("random");
      end

      // Overflow behaviour with a huge learning rate.
      areset("rst_sat");
      step(SFP_ONE, 0, 1'b1, SFP_MAX, SFP_ONE);
      check_state("sat.first");
`ifdef PERCEPTRON_SATURATE_EN
      check("sat.w0_max", dut.weight_q[0], SFP_MAX);
`else
      step(SFP_ONE, 0, 1'b1, SFP_MAX, SFP_ONE);
      check_state("wrap.second");
      check("wrap.w0_neg", {63'd0, dut.weight_q[0][63]}, 64'sd1);
`endif
      for (int i = 0; i < 4; i++) begin
         step(SFP_ONE, 0, 1'b1, SFP_MAX, SFP_ONE);
         check_state("ovf.repeat");
      end
`ifdef PERCEPTRON_SATURATE_EN
      check("sat.w0_stuck", dut.weight_q[0], SFP_MAX);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
